waterfall_light_core: RTL and testbench
=======================================

// Module: waterfall_light_core
// PURPOSE
//  LED chaser engine sitting directly downstream of the Waterfall_Light AXI4-Lite slave registers.
//  It consumes the control, period and pattern register fields and produces the registered LED vector.
//  Modes: rotate (wrap-around) or bounce (reverse at the ends).
//  A programmable prescaler sets the step rate.
// PARAMETERS
//  LED_WIDTH     8   number of LED outputs (>=2)
//  PERIOD_WIDTH  32  width of step-period field (matches 32-bit slave register)
// PORTS
//  clock        in   1             system clock; the only clock
//  reset        in   1             synchronous, active-high reset
//  ctrl_enable  in   1             1 = run; 0 = hold LEDs (slv_reg0[0])
//  ctrl_dir     in   1             start direction: 0 = toward MSB, 1 = toward LSB (slv_reg0[1])
//  ctrl_bounce  in   1             0 = rotate, 1 = bounce (slv_reg0[2])
//  period       in   PERIOD_WIDTH  clock cycles per step; 0 treated as 1 (slv_reg1)
//  pattern      in   LED_WIDTH     pattern loaded on load (slv_reg2[LED_WIDTH-1:0])
//  load         in   1             1-cycle pulse: load pattern and ctrl_dir, clear prescaler
//  led          out  LED_WIDTH     registered LED drive
//  step         out  1             1-cycle pulse on each cycle in which led advanced
//  running      out  1             1 while FSM in RUN
//  cur_dir      out  1             current effective direction (dir_q)
// BEHAVIOUR
//  Reset (reset=1 at posedge) sets:
//   - led = 1 (LSB lit), cnt = 0, dir_q = 0, step = 0, state = IDLE, running = 0.
//  FSM states:
//   - IDLE: ctrl_enable=1 -> RUN, with cnt = 0 and dir_q = ctrl_dir.
//   - RUN: ctrl_enable=0 -> IDLE, with cnt = 0; led holds its value.
//  Prescaler (RUN only):
//   - Let P = (period==0) ? 1 : period.
//   - If cnt >= P-1: cnt <= 0 and a step occurs; otherwise cnt <= cnt+1.
//   - The >= compare makes a mid-run period decrease step on the next cycle; no lockup.
//   - First step occurs P cycles after the first RUN cycle.
//  Step timing:
//   - led and step update on the same edge; step is high for exactly that one cycle.
//   - With P=1, step is continuously high.
//  Rotate step (ctrl_bounce=0):
//   - dir_q=0: led <= {led[W-2:0], led[W-1]}.
//   - dir_q=1: led <= {led[0], led[W-1:1]}.
//  Bounce step (ctrl_bounce=1): logical shift with reversal at the ends.
//   - dir_q=0 and led[W-1]=1 (and led[0]=0): dir_q <= 1, led <= led>>1.
//   - dir_q=1 and led[0]=1 (and led[W-1]=0): dir_q <= 0, led <= led<<1.
//   - Both led[W-1] and led[0] set: led holds, dir_q toggles.
//   - Otherwise: shift in dir_q direction, zero fill.
//  led==0: steps still counted and pulsed; led stays 0.
//  load (any state):
//   - led <= pattern, dir_q <= ctrl_dir, cnt <= 0.
//   - Has priority over a coincident step: no step pulse that cycle.
//   - Does not change FSM state.
//  ctrl_bounce / ctrl_dir changes take effect as follows:
//   - ctrl_bounce is sampled at each step.
//   - ctrl_dir is sampled only on load or on the IDLE->RUN entry.
//  reset mid-run: overrides everything the same cycle (including load).
// TESTING
//  1 reset; enable=1, period=3, dir=0, rotate -> step every 3 clk; led 01->02->04, 80->01 wrap.
//  2 period=0 -> treated as 1; step held high; led advances every clk.
//  3 bounce, load pattern=0x40, dir=0, period=1 -> led 40,80,40,20 ... 01,02; cur_dir flips at 80 and at 01.
//  4 running, period=100, cnt~50; period written 10 -> step next clk, then every 10 clk.
//  5 load coincident with step, pattern=0xA5 -> led=A5, step=0, next step exactly P clk later.
//  6 enable 1->0 mid-run -> led frozen, running=0; re-enable -> first step P clk later, dir from ctrl_dir.

Source files
------------

// File: rtl/waterfall_light_core.sv
// waterfall_light_core: LED chaser with rotate/bounce modes and a programmable step prescaler
module waterfall_light_core #(
  parameter int LED_WIDTH    = 8,
  parameter int PERIOD_WIDTH = 32
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    ctrl_enable,
  input  logic                    ctrl_dir,
  input  logic                    ctrl_bounce,
  input  logic [PERIOD_WIDTH-1:0] period,
  input  logic [LED_WIDTH-1:0]    pattern,
  input  logic                    load,
  output logic [LED_WIDTH-1:0]    led,
  output logic                    step,
  output logic                    running,
  output logic                    cur_dir
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t                  state_q, state_d;
  logic [PERIOD_WIDTH-1:0] cnt_q, cnt_d, pm1;
  logic [LED_WIDTH-1:0]    led_q, led_d, led_adv;
  logic                    dir_q, dir_d, dir_adv, step_q, step_d;
  logic                    msb, lsb;
  assign msb = led_q[LED_WIDTH-1];
  assign lsb = led_q[0];
  assign pm1 = (period == '0) ? '0 : period - 1'b1;
  always_comb begin
    led_adv = dir_q ? {lsb, led_q[LED_WIDTH-1:1]} : {led_q[LED_WIDTH-2:0], msb};
    dir_adv = dir_q;
    if (ctrl_bounce) begin
      if (msb && lsb) begin
        led_adv = led_q;
        dir_adv = ~dir_q;
      end else if (!dir_q && msb) begin
        led_adv = led_q >> 1;
        dir_adv = 1'b1;
      end else if (dir_q && lsb) begin
        led_adv = led_q << 1;
        dir_adv = 1'b0;
      end else begin
        led_adv = dir_q ? led_q >> 1 : led_q << 1;
      end
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    led_d   = led_q;
    dir_d   = dir_q;
    step_d  = 1'b0;
    if (state_q == IDLE) begin
      if (ctrl_enable) begin
        state_d = RUN;
        cnt_d   = '0;
        dir_d   = ctrl_dir;
      end
    end else if (!ctrl_enable) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (cnt_q >= pm1) begin
      cnt_d  = '0;
      step_d = 1'b1;
      led_d  = led_adv;
      dir_d  = dir_adv;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
    // load wins over a coincident step but leaves the FSM state alone
    if (load) begin
      led_d  = pattern;
      dir_d  = ctrl_dir;
      cnt_d  = '0;
      step_d = 1'b0;
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      led_q   <= {{(LED_WIDTH-1){1'b0}}, 1'b1};
      dir_q   <= 1'b0;
      step_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      led_q   <= led_d;
      dir_q   <= dir_d;
      step_q  <= step_d;
    end
  end
  assign led     = led_q;
  assign step    = step_q;
  assign running = (state_q == RUN);
  assign cur_dir = dir_q;
endmodule

// File: tb/tb_waterfall_light_core.sv
// tb_waterfall_light_core: directed vector table plus multi-cycle sequences for the LED chaser
module tb_waterfall_light_core;
  logic        clock = 1'b0;
  logic        reset, ctrl_enable, ctrl_dir, ctrl_bounce, load;
  logic [31:0] period;
  logic [7:0]  pattern, led;
  logic        step, running, cur_dir;
  int          n_vec = 0, n_bad = 0;
  waterfall_light_core #(.LED_WIDTH(8), .PERIOD_WIDTH(32)) dut (
    .clock(clock), .reset(reset), .ctrl_enable(ctrl_enable), .ctrl_dir(ctrl_dir),
    .ctrl_bounce(ctrl_bounce), .period(period), .pattern(pattern), .load(load),
    .led(led), .step(step), .running(running), .cur_dir(cur_dir)
  );
  always #5 clock = ~clock;
  typedef struct {
    logic        rst, en, dir, bnc, ld;
    logic [31:0] per;
    logic [7:0]  pat, e_led;
    logic        e_step, e_run, e_dir;
  } vec_t;
  vec_t vq[$];
  function automatic vec_t mk(logic rst, en, dir, bnc, ld, logic [31:0] per, logic [7:0] pat,
                              logic [7:0] e_led, logic e_step, e_run, e_dir);
    vec_t v;
    v = '{rst, en, dir, bnc, ld, per, pat, e_led, e_step, e_run, e_dir};
    return v;
  endfunction
  task automatic tick;
    @(posedge clock);
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, got, exp);
    end
  endtask
  initial begin
    logic quiet;
    reset = 1'b1; ctrl_enable = 1'b0; ctrl_dir = 1'b0; ctrl_bounce = 1'b0;
    load = 1'b0; period = 32'd3; pattern = 8'h00;
    // reset, rotate with period 3 and wrap
    vq.push_back(mk(1,0,0,0,0,3,8'h00, 8'h01,0,0,0));
    vq.push_back(mk(0,1,0,0,0,3,8'h00, 8'h01,0,1,0));
    vq.push_back(mk(0,1,0,0,0,3,8'h00, 8'h01,0,1,0));
    vq.push_back(mk(0,1,0,0,0,3,8'h00, 8'h01,0,1,0));
    vq.push_back(mk(0,1,0,0,0,3,8'h00, 8'h02,1,1,0));
    vq.push_back(mk(0,1,0,0,0,3,8'h00, 8'h02,0,1,0));
    vq.push_back(mk(0,1,0,0,0,3,8'h00, 8'h02,0,1,0));
    vq.push_back(mk(0,1,0,0,0,3,8'h00, 8'h04,1,1,0));
    vq.push_back(mk(0,1,0,0,1,3,8'h80, 8'h80,0,1,0));
    vq.push_back(mk(0,1,0,0,0,3,8'h00, 8'h80,0,1,0));
    vq.push_back(mk(0,1,0,0,0,3,8'h00, 8'h80,0,1,0));
    vq.push_back(mk(0,1,0,0,0,3,8'h00, 8'h01,1,1,0));
    // period 0 behaves as 1
    vq.push_back(mk(0,1,0,0,0,0,8'h00, 8'h02,1,1,0));
    vq.push_back(mk(0,1,0,0,0,0,8'h00, 8'h04,1,1,0));
    vq.push_back(mk(0,1,0,0,0,0,8'h00, 8'h08,1,1,0));
    vq.push_back(mk(0,1,1,0,1,0,8'h01, 8'h01,0,1,1));
    vq.push_back(mk(0,1,1,0,0,0,8'h00, 8'h80,1,1,1));
    vq.push_back(mk(0,1,1,0,0,0,8'h00, 8'h40,1,1,1));
    // bounce from 0x40
    vq.push_back(mk(0,1,0,1,1,1,8'h40, 8'h40,0,1,0));
    vq.push_back(mk(0,1,0,1,0,1,8'h00, 8'h80,1,1,0));
    vq.push_back(mk(0,1,0,1,0,1,8'h00, 8'h40,1,1,1));
    vq.push_back(mk(0,1,0,1,0,1,8'h00, 8'h20,1,1,1));
    vq.push_back(mk(0,1,0,1,0,1,8'h00, 8'h10,1,1,1));
    vq.push_back(mk(0,1,0,1,0,1,8'h00, 8'h08,1,1,1));
    vq.push_back(mk(0,1,0,1,0,1,8'h00, 8'h04,1,1,1));
    vq.push_back(mk(0,1,0,1,0,1,8'h00, 8'h02,1,1,1));
    vq.push_back(mk(0,1,0,1,0,1,8'h00, 8'h01,1,1,1));
    vq.push_back(mk(0,1,0,1,0,1,8'h00, 8'h02,1,1,0));
    vq.push_back(mk(0,1,0,1,0,1,8'h00, 8'h04,1,1,0));
    // both ends lit: hold and toggle direction
    vq.push_back(mk(0,1,0,1,1,1,8'h81, 8'h81,0,1,0));
    vq.push_back(mk(0,1,0,1,0,1,8'h00, 8'h81,1,1,1));
    vq.push_back(mk(0,1,0,1,0,1,8'h00, 8'h81,1,1,0));
    // all-dark pattern still pulses step
    vq.push_back(mk(0,1,0,1,1,1,8'h00, 8'h00,0,1,0));
    vq.push_back(mk(0,1,0,1,0,1,8'h00, 8'h00,1,1,0));
    // reset beats a coincident load
    vq.push_back(mk(1,1,1,1,1,1,8'hFF, 8'h01,0,0,0));
    #2;
    foreach (vq[i]) begin
      reset = vq[i].rst; ctrl_enable = vq[i].en; ctrl_dir = vq[i].dir;
      ctrl_bounce = vq[i].bnc; load = vq[i].ld; period = vq[i].per; pattern = vq[i].pat;
      tick();
      n_vec++;
      if ({led, step, running, cur_dir} !== {vq[i].e_led, vq[i].e_step, vq[i].e_run, vq[i].e_dir}) begin
        n_bad++;
        $display("FAIL vec%0d: got led=%h step=%b run=%b dir=%b want led=%h step=%b run=%b dir=%b",
                 i, led, step, running, cur_dir, vq[i].e_led, vq[i].e_step, vq[i].e_run, vq[i].e_dir);
      end
    end
    // period shrinks mid-count: step on the next edge, then every 10
    reset = 1'b0; ctrl_enable = 1'b1; ctrl_dir = 1'b0; ctrl_bounce = 1'b0;
    load = 1'b0; period = 32'd100; pattern = 8'h00;
    tick();
    chk("enter_run", {31'd0, running}, 32'd1);
    quiet = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      quiet &= ~step;
    end
    chk("p100_quiet", {31'd0, quiet}, 32'd1);
    period = 32'd10;
    tick();
    chk("shrink_step", {23'd0, led, step}, {23'd0, 8'h02, 1'b1});
    quiet = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      quiet &= ~step;
    end
    chk("p10_quiet", {31'd0, quiet}, 32'd1);
    tick();
    chk("p10_step", {23'd0, led, step}, {23'd0, 8'h04, 1'b1});
    // load on the cycle a step would fire
    for (int i = 0; i < 9; i++) tick();
    load = 1'b1; pattern = 8'hA5;
    tick();
    load = 1'b0;
    chk("load_wins", {23'd0, led, step}, {23'd0, 8'hA5, 1'b0});
    quiet = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      quiet &= ~step;
    end
    chk("after_load_quiet", {31'd0, quiet}, 32'd1);
    tick();
    chk("after_load_step", {23'd0, led, step}, {23'd0, 8'h4B, 1'b1});
    // disable freezes LEDs; re-enable picks up ctrl_dir
    for (int i = 0; i < 3; i++) tick();
    ctrl_enable = 1'b0;
    tick();
    chk("disable", {22'd0, led, step, running}, {22'd0, 8'h4B, 1'b0, 1'b0});
    for (int i = 0; i < 20; i++) tick();
    chk("frozen", {22'd0, led, step, running}, {22'd0, 8'h4B, 1'b0, 1'b0});
    ctrl_dir = 1'b1; ctrl_enable = 1'b1;
    tick();
    chk("reenable", {30'd0, running, cur_dir}, 32'd3);
    quiet = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      quiet &= ~step;
    end
    chk("reenable_quiet", {31'd0, quiet}, 32'd1);
    tick();
    chk("reenable_step", {23'd0, led, step}, {23'd0, 8'hA5, 1'b1});
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
